// File: rtl/renderizador_pkg.sv
// Shared definitions for the VGA frame renderer.
// Holds 640x480@60 Hz timing constants, the vertical-blank latch line,
// fixed colours, entity record types and a helper that squares a signed
// distance.
package renderizador_pkg;

  localparam int unsigned HVisible = 640;
  localparam int unsigned HFront   = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HTotal   = 800;

  localparam int unsigned VVisible = 480;
  localparam int unsigned VFront   = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VTotal   = 525;

  // Line on which entity positions are captured (first blanked line).
  localparam int unsigned VLatch   = 480;

  localparam logic [23:0] CorBranca = 24'hFFFFFF;
  localparam logic [23:0] CorPreta  = 24'h000000;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] r;
  } bola_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
  } nave_t;

  // |d|^2 as an unsigned 21-bit value; -1024 maps to magnitude 1024.
  function automatic logic [20:0] quadrado(input logic signed [10:0] d);
    logic [10:0] mag;
    mag = d[10] ? 11'(-d) : 11'(d);
    return 21'(mag) * 21'(mag);
  endfunction

endpackage

// File: rtl/vga_sync.sv
// VGA timing generator.
// Ports: clk_i / rst_i (async, active high); pe_o pixel enable toggling every
// clock; h_o / v_o pixel and line counters; hsync_o / vsync_o high while the
// counters sit in the sync region; visible_o high in the 640x480 active area.
module vga_sync
  import renderizador_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       pe_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       visible_o
);

  logic       pe_q, pe_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    pe_d = ~pe_q;
    h_d  = h_q;
    v_d  = v_q;
    if (pe_q) begin
      if (h_q == 10'(HTotal - 1)) begin
        h_d = '0;
        v_d = (v_q == 10'(VTotal - 1)) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pe_q <= 1'b0;
      h_q  <= '0;
      v_q  <= '0;
    end else begin
      pe_q <= pe_d;
      h_q  <= h_d;
      v_q  <= v_d;
    end
  end

  assign pe_o      = pe_q;
  assign h_o       = h_q;
  assign v_o       = v_q;
  assign hsync_o   = (h_q >= 10'(HVisible + HFront)) && (h_q < 10'(HVisible + HFront + HSync));
  assign vsync_o   = (v_q >= 10'(VVisible + VFront)) && (v_q < 10'(VVisible + VFront + VSync));
  assign visible_o = (h_q < 10'(HVisible)) && (v_q < 10'(VVisible));

endmodule

// File: rtl/renderizador_vga.sv
// Frame renderer: draws a ship rectangle and two balls on a 640x480@60 Hz
// VGA raster clocked from CLOCK_50 (25 MHz pixel enable).
// Ports: CLOCK_50, reset (async, active high); ball centre/radius and ship
// corner/size inputs (10 bits each); VGA_R/G/B colour, VGA_HS/VGA_VS
// (active low), VGA_BLANK_N, VGA_SYNC_N (tied 0), VGA_CLK (pixel enable);
// frame_tick pulses one clock when entity positions are captured.
// Entity inputs are shadowed once per frame at the start of vertical blank.
// Outputs are two pixel periods behind the counters.
// Optional: define RENDER_BORDA_EN to draw a white 1-pixel frame border.
module renderizador_vga
  import renderizador_pkg::*;
#(
  parameter logic [23:0] COR_FUNDO   = 24'h000000,
  parameter logic [23:0] COR_NAVE    = 24'h00FF00,
  parameter logic [23:0] COR_ALIADA  = 24'h00FFFF,
  parameter logic [23:0] COR_INIMIGA = 24'hFF0000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] x_bola_aliada,
  input  logic [9:0] y_bola_aliada,
  input  logic [9:0] raio_bola_aliada,
  input  logic [9:0] x_bola_inimiga,
  input  logic [9:0] y_bola_inimiga,
  input  logic [9:0] raio_bola_inimiga,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] largura_nave,
  input  logic [9:0] altura_nave,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_tick
);

  logic       pe, hs_raw, vs_raw, vis_raw;
  logic [9:0] h, v;

  vga_sync u_sync (
    .clk_i     (CLOCK_50),
    .rst_i     (reset),
    .pe_o      (pe),
    .h_o       (h),
    .v_o       (v),
    .hsync_o   (hs_raw),
    .vsync_o   (vs_raw),
    .visible_o (vis_raw)
  );

  logic latch;
  assign latch = pe && (h == '0) && (v == 10'(VLatch));

  // Shadow registers and frame tick.
  bola_t aliada_q, aliada_d, inimiga_q, inimiga_d;
  nave_t nave_q, nave_d;
  logic  frame_tick_q, frame_tick_d;

  always_comb begin
    aliada_d     = latch ? '{x_bola_aliada, y_bola_aliada, raio_bola_aliada} : aliada_q;
    inimiga_d    = latch ? '{x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga} : inimiga_q;
    nave_d       = latch ? '{x_nave, y_nave, largura_nave, altura_nave} : nave_q;
    frame_tick_d = latch;
  end

  // Stage 1: distances and ship hit. Ship bounds kept in 11 bits so a
  // rectangle past 1023 clips rather than wraps.
  logic signed [10:0] dx_ali_q, dx_ali_d, dy_ali_q, dy_ali_d;
  logic signed [10:0] dx_ini_q, dx_ini_d, dy_ini_q, dy_ini_d;
  logic               nave_hit_q, nave_hit_d;
  logic               hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
  logic [10:0]        h11, v11, nave_x_fim, nave_y_fim;

  assign h11        = {1'b0, h};
  assign v11        = {1'b0, v};
  assign nave_x_fim = {1'b0, nave_q.x} + {1'b0, nave_q.w};
  assign nave_y_fim = {1'b0, nave_q.y} + {1'b0, nave_q.h};

`ifdef RENDER_BORDA_EN
  logic borda1_q, borda1_d;
`endif

  always_comb begin
    dx_ali_d   = dx_ali_q;
    dy_ali_d   = dy_ali_q;
    dx_ini_d   = dx_ini_q;
    dy_ini_d   = dy_ini_q;
    nave_hit_d = nave_hit_q;
    hs1_d      = hs1_q;
    vs1_d      = vs1_q;
    vis1_d     = vis1_q;
`ifdef RENDER_BORDA_EN
    borda1_d   = borda1_q;
`endif
    if (pe) begin
      dx_ali_d   = $signed(h11) - $signed({1'b0, aliada_q.x});
      dy_ali_d   = $signed(v11) - $signed({1'b0, aliada_q.y});
      dx_ini_d   = $signed(h11) - $signed({1'b0, inimiga_q.x});
      dy_ini_d   = $signed(v11) - $signed({1'b0, inimiga_q.y});
      nave_hit_d = (h11 >= {1'b0, nave_q.x}) && (h11 < nave_x_fim) &&
                   (v11 >= {1'b0, nave_q.y}) && (v11 < nave_y_fim);
      hs1_d      = hs_raw;
      vs1_d      = vs_raw;
      vis1_d     = vis_raw;
`ifdef RENDER_BORDA_EN
      borda1_d   = (h == '0) || (h == 10'(HVisible - 1)) ||
                   (v == '0) || (v == 10'(VVisible - 1));
`endif
    end
  end

  // Stage 2: circle tests and colour mux. Radius 0 disables a ball.
  logic [21:0] soma_ali, soma_ini;
  logic [19:0] r2_ali, r2_ini;
  logic        hit_ali, hit_ini;
  logic [23:0] cor;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_n_q, hs_n_d, vs_n_q, vs_n_d, blank_n_q, blank_n_d;

  assign soma_ali = 22'(quadrado(dx_ali_q)) + 22'(quadrado(dy_ali_q));
  assign soma_ini = 22'(quadrado(dx_ini_q)) + 22'(quadrado(dy_ini_q));
  assign r2_ali   = 20'(aliada_q.r) * 20'(aliada_q.r);
  assign r2_ini   = 20'(inimiga_q.r) * 20'(inimiga_q.r);
  assign hit_ali  = (aliada_q.r != '0) && (soma_ali <= 22'(r2_ali));
  assign hit_ini  = (inimiga_q.r != '0) && (soma_ini <= 22'(r2_ini));

  always_comb begin
    cor = COR_FUNDO;
`ifdef RENDER_BORDA_EN
    if (borda1_q) cor = CorBranca;
`endif
    if (nave_hit_q) cor = COR_NAVE;
    if (hit_ali)    cor = COR_ALIADA;
    if (hit_ini)    cor = COR_INIMIGA;

    rgb_d     = rgb_q;
    hs_n_d    = hs_n_q;
    vs_n_d    = vs_n_q;
    blank_n_d = blank_n_q;
    if (pe) begin
      rgb_d     = vis1_q ? cor : CorPreta;
      hs_n_d    = ~hs1_q;
      vs_n_d    = ~vs1_q;
      blank_n_d = vis1_q;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      aliada_q     <= '0;
      inimiga_q    <= '0;
      nave_q       <= '0;
      frame_tick_q <= 1'b0;
      dx_ali_q     <= '0;
      dy_ali_q     <= '0;
      dx_ini_q     <= '0;
      dy_ini_q     <= '0;
      nave_hit_q   <= 1'b0;
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      vis1_q       <= 1'b0;
`ifdef RENDER_BORDA_EN
      borda1_q     <= 1'b0;
`endif
      rgb_q        <= '0;
      hs_n_q       <= 1'b1;
      vs_n_q       <= 1'b1;
      blank_n_q    <= 1'b0;
    end else begin
      aliada_q     <= aliada_d;
      inimiga_q    <= inimiga_d;
      nave_q       <= nave_d;
      frame_tick_q <= frame_tick_d;
      dx_ali_q     <= dx_ali_d;
      dy_ali_q     <= dy_ali_d;
      dx_ini_q     <= dx_ini_d;
      dy_ini_q     <= dy_ini_d;
      nave_hit_q   <= nave_hit_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      vis1_q       <= vis1_d;
`ifdef RENDER_BORDA_EN
      borda1_q     <= borda1_d;
`endif
      rgb_q        <= rgb_d;
      hs_n_q       <= hs_n_d;
      vs_n_q       <= vs_n_d;
      blank_n_q    <= blank_n_d;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_n_q;
  assign VGA_VS      = vs_n_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pe;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_renderizador_vga.sv
// Bench for renderizador_vga: every pixel is predicted from the geometric
// rules (distances, rectangles, raster position) and compared two pixel
// periods later through a queue. Runs two and a half frames with directed and
// random entity placements, then a mid-frame reset.
module tb_renderizador_vga;

  localparam logic [23:0] Fundo   = 24'h000000;
  localparam logic [23:0] Nave    = 24'h00FF00;
  localparam logic [23:0] Aliada  = 24'h00FFFF;
  localparam logic [23:0] Inimiga = 24'hFF0000;
  localparam int FramePix = 800 * 525;
  localparam int LatchPix = 800 * 480;
  // frame_tick first seen after the clock edge that consumes the latch pixel
  localparam int unsigned TickCyc0   = 2 * LatchPix + 2;
  localparam int unsigned TickPeriod = 2 * FramePix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] xa = '0, ya = '0, ra = '0, xi = '0, yi = '0, ri = '0;
  logic [9:0] xn = '0, yn = '0, wn = '0, hn = '0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_tick;

  always #10 clk = ~clk;

  renderizador_vga dut (
    .CLOCK_50          (clk),
    .reset             (rst),
    .x_bola_aliada     (xa),
    .y_bola_aliada     (ya),
    .raio_bola_aliada  (ra),
    .x_bola_inimiga    (xi),
    .y_bola_inimiga    (yi),
    .raio_bola_inimiga (ri),
    .x_nave            (xn),
    .y_nave            (yn),
    .largura_nave      (wn),
    .altura_nave       (hn),
    .VGA_R             (vga_r),
    .VGA_G             (vga_g),
    .VGA_B             (vga_b),
    .VGA_HS            (vga_hs),
    .VGA_VS            (vga_vs),
    .VGA_BLANK_N       (vga_blank_n),
    .VGA_SYNC_N        (vga_sync_n),
    .VGA_CLK           (vga_clk),
    .frame_tick        (frame_tick)
  );

  typedef struct {
    int xa, ya, ra, xi, yi, ri, xn, yn, wn, hn;
  } cfg_t;

  typedef struct {
    int          pix;
    logic [23:0] rgb;
    logic        hs, vs, bl;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // Clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic finish_test();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      if (errors >= 40) finish_test();
    end
  endtask

  function automatic cfg_t cur_cfg();
    cfg_t c;
    c.xa = int'(xa); c.ya = int'(ya); c.ra = int'(ra);
    c.xi = int'(xi); c.yi = int'(yi); c.ri = int'(ri);
    c.xn = int'(xn); c.yn = int'(yn); c.wn = int'(wn); c.hn = int'(hn);
    return c;
  endfunction

  function automatic logic in_ball(input int h, input int v, input int x, input int y,
                                   input int r);
    return (r != 0) && ((h - x) * (h - x) + (v - y) * (v - y) <= r * r);
  endfunction

  function automatic logic [23:0] pixel_colour(input cfg_t c, input int h, input int v);
    if (!(h < 640 && v < 480)) return 24'h000000;
    if (in_ball(h, v, c.xi, c.yi, c.ri)) return Inimiga;
    if (in_ball(h, v, c.xa, c.ya, c.ra)) return Aliada;
    if (h >= c.xn && h < c.xn + c.wn && v >= c.yn && v < c.yn + c.hn) return Nave;
`ifdef RENDER_BORDA_EN
    if (h == 0 || h == 639 || v == 0 || v == 479) return 24'hFFFFFF;
`endif
    return Fundo;
  endfunction

  // Reference: pixel k is on the counters from clock 2k; entity positions
  // apply from the pixel after the one on line 480, column 0.
  cfg_t shadow;
  always @(negedge clk) begin
    if (!rst && (cyc % 2 == 0)) begin
      int   p, h, v;
      exp_t e;
      p = int'(cyc / 2);
      if (p == 0) begin
        sb.delete();
        shadow = '{default: 0};
      end
      h = p % 800;
      v = (p / 800) % 525;
      e.pix = p;
      e.rgb = pixel_colour(shadow, h, v);
      e.hs  = !(h >= 656 && h < 752);
      e.vs  = !(v >= 490 && v < 492);
      e.bl  = (h < 640) && (v < 480);
      sb.push_back(e);
      if (h == 0 && v == 480) shadow = cur_cfg();
    end
  end

  // Monitor: output for pixel k appears at clock 2k+4.
  always @(negedge clk) begin
    if (!rst) begin
      chk("frame_tick", 32'(frame_tick),
          32'(cyc >= TickCyc0 && ((cyc - TickCyc0) % TickPeriod) == 0));
      chk("vga_clk", 32'(vga_clk), 32'(cyc[0]));
      chk("sync_n", 32'(vga_sync_n), 32'd0);
      if (cyc % 2 == 0 && cyc >= 4) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          int   f, h, v;
          logic [23:0] rgb;
          e   = sb.pop_front();
          rgb = {vga_r, vga_g, vga_b};
          chk("rgb", 32'(rgb), 32'(e.rgb));
          chk("hsync", 32'(vga_hs), 32'(e.hs));
          chk("vsync", 32'(vga_vs), 32'(e.vs));
          chk("blank_n", 32'(vga_blank_n), 32'(e.bl));
          f = e.pix / FramePix;
          h = e.pix % 800;
          v = (e.pix / 800) % 525;
          if (f == 1 && h == 105 && v == 100) chk("ally_edge", 32'(rgb), 32'(Aliada));
          if (f == 1 && h == 106 && v == 100) chk("ally_out", 32'(rgb), 32'(Fundo));
          if (f == 1 && h == 104 && v == 103) chk("ally_diag", 32'(rgb), 32'(Aliada));
          if (f == 1 && h == 639 && v == 479) chk("ship_corner", 32'(rgb), 32'(Nave));
          if (f == 1 && h == 629 && v == 478) chk("ship_left", 32'(rgb), 32'(Fundo));
          if (f == 2 && h == 101 && v == 100) chk("enemy_prio", 32'(rgb), 32'(Inimiga));
        end
      end
    end
  end

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic randomize_inputs();
    xa = 10'($urandom); ya = 10'($urandom); ra = 10'($urandom_range(0, 60));
    xi = 10'($urandom); yi = 10'($urandom); ri = 10'($urandom_range(0, 60));
    xn = 10'($urandom); yn = 10'($urandom); wn = 10'($urandom); hn = 10'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
    chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
    chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
    chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Frame 0: churn inputs; nothing is drawn before the first latch.
    for (int unsigned t = 20000; t < 752000; t += 20000) begin
      wait_cyc(t);
      randomize_inputs();
    end
    wait_cyc(752000);
    xa = 10'd100; ya = 10'd100; ra = 10'd5;
    xi = 10'($urandom_range(300, 600)); yi = 10'($urandom_range(200, 400));
    ri = 10'($urandom_range(0, 30));
    xn = 10'd630; yn = 10'd470; wn = 10'd20; hn = 10'd20;

    // After the latch, input churn must not reach frame 1.
    for (int unsigned t = TickCyc0 + 100; t < 2 * (FramePix + 200 * 800); t += 30000) begin
      wait_cyc(t);
      randomize_inputs();
    end

    // Mid-frame-1 change (line 200): appears only in frame 2.
    wait_cyc(2 * (FramePix + 200 * 800));
    xi = 10'd100; yi = 10'd100; ri = 10'd5;
    xa = 10'd102; ya = 10'd100; ra = 10'd5;
    xn = 10'($urandom_range(0, 700)); yn = 10'($urandom_range(0, 190));
    wn = 10'($urandom); hn = 10'($urandom);

    wait_cyc(TickCyc0 + TickPeriod + 100);
    randomize_inputs();

    // Reset at frame 2, h=300, v=200.
    wait_cyc(2 * (2 * FramePix + 200 * 800 + 300));
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("mid_rst_hold");
    rst = 1'b0;

    // A few lines to confirm timing restarts from (0,0).
    wait_cyc(2 * 800 * 3 + 100);
    finish_test();
  end

endmodule
